// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_fsm_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_unit_forward_sel.sv
// EX-stage operand forwarding select for one source register; Memory stage wins over Writeback.
module forward_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_m,
  input  logic                      reg_write_w,
  output fwd_sel_t                  fwd_c
);

  always_comb begin
    fwd_c = FWD_REG;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      fwd_c = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      fwd_c = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush/forward controller for the 5-stage RV32I pipeline with a memory-wait FSM and watchdog.
// Optional perf counters are built when HAZARD_PERF_COUNTERS_EN is defined.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT    = 64
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  parameter int unsigned CNT_WIDTH      = 32
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic [1:0]                ResultSrcE,
  input  logic                      PCSrcE,
  input  logic                      MemReqM,
  input  logic                      MemReadyM,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic                      MemTimeoutErr,
  output logic                      MemWaitActive
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0]      LoadUseStallCnt,
  output logic [CNT_WIDTH-1:0]      MemStallCnt,
  output logic [CNT_WIDTH-1:0]      FlushCnt
`endif
);

  localparam int unsigned WD_WIDTH = $clog2(MEM_TIMEOUT);
  localparam logic [WD_WIDTH-1:0] WD_MAX = WD_WIDTH'(MEM_TIMEOUT - 1);

  mem_fsm_t            state_q;
  mem_fsm_t            state_d;
  logic [WD_WIDTH-1:0] wd_cnt_q;
  logic                mem_stall_c;
  logic                lw_stall_c;
  fwd_sel_t            fwd_a_c;
  fwd_sel_t            fwd_b_c;

  forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_c       (fwd_a_c)
  );

  forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_c       (fwd_b_c)
  );

  assign mem_stall_c = MemReqM && !MemReadyM;
  assign lw_stall_c  = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));

  assign ForwardAE = rst ? FWD_REG : fwd_a_c;
  assign ForwardBE = rst ? FWD_REG : fwd_b_c;

  // Next state and stall/flush decode; a memory stall freezes everything and masks branch/load-use.
  always_comb begin
    state_d = state_q;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushW  = 1'b0;

    case (state_q)
      RUN:      if (mem_stall_c) state_d = MEM_WAIT;
      MEM_WAIT: if (MemReadyM)   state_d = RUN;
      default:  state_d = RUN;
    endcase

    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall_c) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall_c;
      StallD = lw_stall_c;
      FlushD = PCSrcE;
      FlushE = lw_stall_c || PCSrcE;
    end
  end

  // State, saturating watchdog and sticky timeout error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wd_cnt_q      <= '0;
      MemTimeoutErr <= 1'b0;
      MemWaitActive <= 1'b0;
    end else begin
      state_q       <= state_d;
      MemWaitActive <= (state_d == MEM_WAIT);
      if (state_d == RUN) begin
        wd_cnt_q <= '0;
      end else if ((state_q == MEM_WAIT) && (wd_cnt_q != WD_MAX)) begin
        wd_cnt_q <= wd_cnt_q + WD_WIDTH'(1);
      end
      if ((state_q == MEM_WAIT) && !MemReadyM && (wd_cnt_q == WD_MAX)) begin
        MemTimeoutErr <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  // Wrapping event counters for load-use stalls, memory stall cycles and taken-branch flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      LoadUseStallCnt <= '0;
      MemStallCnt     <= '0;
      FlushCnt        <= '0;
    end else begin
      if (lw_stall_c && !mem_stall_c) LoadUseStallCnt <= LoadUseStallCnt + CNT_WIDTH'(1);
      if (mem_stall_c)                MemStallCnt     <= MemStallCnt + CNT_WIDTH'(1);
      if (PCSrcE && !mem_stall_c)     FlushCnt        <= FlushCnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit (watchdog shortened to 4 cycles).
module tb_hazard_ctrl_unit;

  localparam int unsigned RW = 5;
`ifdef HAZARD_PERF_COUNTERS_EN
  localparam int unsigned CW = 32;
`endif

  logic          clk;
  logic          rst;
  logic [RW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW;
  logic [1:0]    ResultSrcE;
  logic          PCSrcE, MemReqM, MemReadyM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW;
  logic          MemTimeoutErr, MemWaitActive;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CW-1:0] LoadUseStallCnt, MemStallCnt, FlushCnt;
`endif

  int checks = 0;
  int failures = 0;

  hazard_ctrl_unit #(.REG_ADDR_WIDTH(RW), .MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .Rs1D          (Rs1D),
    .Rs2D          (Rs2D),
    .Rs1E          (Rs1E),
    .Rs2E          (Rs2E),
    .RdE           (RdE),
    .RdM           (RdM),
    .RdW           (RdW),
    .RegWriteM     (RegWriteM),
    .RegWriteW     (RegWriteW),
    .ResultSrcE    (ResultSrcE),
    .PCSrcE        (PCSrcE),
    .MemReqM       (MemReqM),
    .MemReadyM     (MemReadyM),
    .ForwardAE     (ForwardAE),
    .ForwardBE     (ForwardBE),
    .StallF        (StallF),
    .StallD        (StallD),
    .StallE        (StallE),
    .StallM        (StallM),
    .FlushD        (FlushD),
    .FlushE        (FlushE),
    .FlushW        (FlushW),
    .MemTimeoutErr (MemTimeoutErr),
    .MemWaitActive (MemWaitActive)
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    .LoadUseStallCnt (LoadUseStallCnt),
    .MemStallCnt     (MemStallCnt),
    .FlushCnt        (FlushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  function automatic logic [6:0] ctl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic idle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", 32'(ctl()), 32'h07);
    chk("rst_fwd_a", 32'(ForwardAE), 32'h0);
    chk("rst_mwa", 32'(MemWaitActive), 32'h0);
    chk("rst_err", 32'(MemTimeoutErr), 32'h0);

    @(negedge clk); rst = 1'b0; idle(); #1;
    chk("idle_ctl", 32'(ctl()), 32'h00);

    // Forwarding priority and x0 handling
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd5; #1;
    chk("fwd_a_mem", 32'(ForwardAE), 32'h2);
    chk("fwd_b_mem", 32'(ForwardBE), 32'h2);
    RegWriteM = 1'b0; #1;
    chk("fwd_a_wb", 32'(ForwardAE), 32'h1);
    RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; #1;
    chk("fwd_a_x0", 32'(ForwardAE), 32'h0);
    RdM = 5'd3; RdW = 5'd9; Rs2E = 5'd9; #1;
    chk("fwd_b_wb", 32'(ForwardBE), 32'h1);

    // Load-use stall followed by the bubble it created
    @(negedge clk); idle(); ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; #1;
    chk("lw_ctl", 32'(ctl()), 32'h62);
    @(negedge clk); idle(); #1;
    chk("lw_after", 32'(ctl()), 32'h00);
    ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0; #1;
    chk("lw_x0", 32'(ctl()), 32'h00);

    // Branch alone and branch coinciding with load-use
    @(negedge clk); idle(); PCSrcE = 1'b1; #1;
    chk("br_ctl", 32'(ctl()), 32'h06);
    ResultSrcE = 2'b01; RdE = 5'd4; Rs1D = 5'd4; #1;
    chk("br_lw_ctl", 32'(ctl()), 32'h66);

    // Three-cycle memory wait with a pending branch
    @(negedge clk); idle(); MemReqM = 1'b1; PCSrcE = 1'b1; #1;
    chk("mw_c0_ctl", 32'(ctl()), 32'h79);
    chk("mw_c0_mwa", 32'(MemWaitActive), 32'h0);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); #1;
      chk($sformatf("mw_c%0d_ctl", i), 32'(ctl()), 32'h79);
      chk($sformatf("mw_c%0d_mwa", i), 32'(MemWaitActive), 32'h1);
    end
    @(negedge clk); MemReadyM = 1'b1; #1;
    chk("mw_rel_ctl", 32'(ctl()), 32'h06);
    chk("mw_rel_mwa", 32'(MemWaitActive), 32'h1);
    @(negedge clk); idle(); #1;
    chk("mw_done_ctl", 32'(ctl()), 32'h00);
    chk("mw_done_mwa", 32'(MemWaitActive), 32'h0);

    // Zero-wait access never stalls
    MemReqM = 1'b1; MemReadyM = 1'b1; #1;
    chk("zw_ctl", 32'(ctl()), 32'h00);
    @(negedge clk); idle(); #1;
    chk("zw_mwa", 32'(MemWaitActive), 32'h0);

    // Watchdog: error after 4 wait cycles, sticky through release
    MemReqM = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      chk($sformatf("to_err_%0d", k), 32'(MemTimeoutErr), (k >= 5) ? 32'h1 : 32'h0);
    end
    chk("to_mwa", 32'(MemWaitActive), 32'h1);
    MemReadyM = 1'b1; #1;
    chk("to_rel_ctl", 32'(ctl()), 32'h00);
    @(negedge clk); idle(); #1;
    chk("to_sticky1", 32'(MemTimeoutErr), 32'h1);
    chk("to_rel_mwa", 32'(MemWaitActive), 32'h0);
    @(negedge clk); #1;
    chk("to_sticky2", 32'(MemTimeoutErr), 32'h1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("to_clear", 32'(MemTimeoutErr), 32'h0);
    rst = 1'b0;

    // Reset asserted in the second MEM_WAIT cycle
    @(negedge clk); idle(); MemReqM = 1'b1; #1;
    @(negedge clk); #1;
    chk("rmw_w1_mwa", 32'(MemWaitActive), 32'h1);
    @(negedge clk); rst = 1'b1; #1;
    chk("rmw_rst_ctl", 32'(ctl()), 32'h07);
    @(negedge clk); rst = 1'b0; idle(); #1;
    chk("rmw_mwa", 32'(MemWaitActive), 32'h0);
    chk("rmw_ctl", 32'(ctl()), 32'h00);
    chk("rmw_err", 32'(MemTimeoutErr), 32'h0);
`ifdef HAZARD_PERF_COUNTERS_EN
    chk("rmw_lu_cnt", LoadUseStallCnt[31:0], 32'h0);
    chk("rmw_ms_cnt", MemStallCnt[31:0], 32'h0);
    chk("rmw_fl_cnt", FlushCnt[31:0], 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Central hazard and sequencing controller for the 5-stage RV32I pipeline.
- Drives stall/flush enables for the fetch, decode, execute, memory and writeback pipeline registers, and the EX-stage forwarding selects.
- Owns a small FSM that holds the pipeline while a multi-cycle data memory access completes. A watchdog counter flags memory accesses that never complete.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- MEM_TIMEOUT, 64, max cycles allowed in MEM_WAIT before sticky error (must be >=2).
- CNT_WIDTH, 32, width of perf counters (feature-gated).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high
- Rs1D, Rs2D  in  5  source regs in Decode
- Rs1E, Rs2E  in  5  source regs in Execute
- RdE, RdM, RdW  in  5  destination regs per stage
- RegWriteM, RegWriteW  in  1  writeback enables per stage
- ResultSrcE  in  2  result select in Execute; 2'b01 = load
- PCSrcE  in  1  branch/jump taken, resolved in Execute
- MemReqM  in  1  load/store active in Memory stage
- MemReadyM  in  1  data memory completion, same-cycle valid
- ForwardAE, ForwardBE  out  2  00 = regfile, 10 = ALUResultM, 01 = ResultW
- StallF, StallD, StallE, StallM  out  1  hold the pipe register feeding that stage
- FlushD, FlushE, FlushW  out  1  load a bubble into that pipe register
- MemTimeoutErr  out  1  sticky watchdog error
- MemWaitActive  out  1  FSM is in MEM_WAIT

Behaviour:
- Reset:
  - State = RUN, watchdog = 0, MemTimeoutErr = 0.
  - While rst is high, all stall outputs = 0, FlushD/E/W = 1 and ForwardAE/BE = 00.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when MemReqM && !MemReadyM.
  - MEM_WAIT -> RUN when MemReadyM. Exit does not depend on the timeout.
- memStall (combinational) = MemReqM && !MemReadyM, evaluated in either state.
  - Zero-wait memory (MemReadyM=1 in the request cycle) causes no stall.
  - The release cycle (MemReadyM=1 in MEM_WAIT) has memStall = 0, so the pipeline advances that same cycle.
- When memStall = 1:
  - StallF = StallD = StallE = StallM = 1.
  - FlushW = 1, so no duplicate writeback occurs.
  - FlushD = FlushE = 0. Branch and load-use actions are suppressed; they re-evaluate on release because the E-stage contents are held.
- lwStall = (ResultSrcE == 01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D).
- When memStall = 0:
  - StallF = StallD = lwStall.
  - FlushD = PCSrcE.
  - FlushE = lwStall || PCSrcE.
  - StallE = StallM = FlushW = 0.
  - If lwStall and PCSrcE occur together, the flush wins for D; F is still stalled for that cycle, which is harmless because FlushD discards the D contents.
- Forwarding, per source (shown for A):
  - 10 if RegWriteM && RdM != 0 && RdM == Rs1E.
  - Else 01 if RegWriteW && RdW != 0 && RdW == Rs1E.
  - Else 00.
  - M has priority over W.
- Watchdog:
  - Counts cycles in MEM_WAIT and clears on entry to RUN.
  - When the count reaches MEM_TIMEOUT-1 while still waiting, MemTimeoutErr is set.
  - The error stays set until rst; the counter saturates.
  - The FSM keeps waiting after the error is raised.
- Reset asserted during MEM_WAIT: returns to RUN next edge with no residual stall.
- MemWaitActive is a registered decode of state == MEM_WAIT.

Optional Feature:
- Macro: HAZARD_PERF_COUNTERS_EN.
- When defined, adds outputs LoadUseStallCnt, MemStallCnt and FlushCnt, each CNT_WIDTH bits.
  - LoadUseStallCnt increments on lwStall && !memStall.
  - MemStallCnt increments on each memStall cycle.
  - FlushCnt increments on each PCSrcE && !memStall cycle.
  - All counters wrap at 2^CNT_WIDTH and clear on rst.
- When undefined, these ports and registers do not exist and the remaining behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum (FWD_REG = 00, FWD_WB = 01, FWD_MEM = 10).
  - mem_fsm_t enum (RUN, MEM_WAIT).
  - RESULT_SRC_LOAD = 2'b01.
- One natural sub-module: forward_sel. It is combinational, instantiated twice (A and B), and takes Rs, RdM, RdW, RegWriteM, RegWriteW.

Test Plan:
- Forwarding:
  - RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10.
  - Drop RegWriteM -> ForwardAE=01.
  - Rs1E=0 with RdM=0 -> ForwardAE=00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle, FlushD=0.
- Branch: PCSrcE=1 -> FlushD=FlushE=1, no stalls. PCSrcE=1 with lwStall -> FlushD=FlushE=StallF=StallD=1.
- Memory wait:
  - MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> StallF/D/E/M=FlushW=1 for 3 cycles, MemWaitActive=1 for the cycles after entry, all stalls 0 on the ready cycle.
  - Concurrent PCSrcE=1 -> FlushD stays 0 until the ready cycle.
- Timeout: MEM_TIMEOUT=4, MemReadyM held 0 -> MemTimeoutErr rises after 4 wait cycles, stays 1 after MemReadyM=1, clears only on rst.
- Reset mid-wait: assert rst in cycle 2 of MEM_WAIT -> next cycle MemWaitActive=0, stalls 0, counter 0. With HAZARD_PERF_COUNTERS_EN defined, all counters read 0.
